// File: rtl/mlp_pkg.sv
// Shared types and helpers for the time-multiplexed perceptron engine.
package mlp_pkg;

   // Engine phases: idle, hidden-layer terms, output-layer terms, result held.
   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_HID  = 2'd1;
   localparam state_t S_OUT  = 2'd2;
   localparam state_t S_DONE = 2'd3;

   // Accumulator width: full product plus growth for N_IN+1 terms plus one spare bit.
   function automatic int acc_w(input int dw, input int n_in);
      return 2*dw + $clog2(n_in+1) + 1;
   endfunction

   // Hidden-neuron coefficient address: inputs 0..n_in-1 are weights, index n_in is the bias.
   function automatic int coef_addr(input int j, input int i, input int n_in);
      return j*(n_in+1) + i;
   endfunction

   // Step activation: fires only on a strictly positive accumulator.
   function automatic logic step(input logic sign_bit, input logic nonzero);
      return ~sign_bit & nonzero;
   endfunction

endpackage

// File: rtl/mlp_mac.sv
// Shared multiply-accumulate unit: one signed DW x DW product added per enabled cycle.
module mlp_mac #(
   parameter int DW    = 10,
   parameter int ACC_W = 23
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    b,
   output logic signed [ACC_W-1:0] sum
);

   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] acc_reg;

   // Operands are sign-extended before multiplying so the product is exact.
   assign prod = (2*DW)'(a) * (2*DW)'(b);

   // sum is the value the accumulator would take this cycle; the caller
   // activates on it directly when this is the last term of a neuron.
   assign sum = acc_reg + ACC_W'(prod);

   // Accumulator: clear has priority so a neuron can finish and restart in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_reg <= '0;
      else if (clr)
         acc_reg <= '0;
      else if (en)
         acc_reg <= sum;
   end

endmodule

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed N_IN-N_HID-1 perceptron network with a writable coefficient file.
module mlp_seq_engine
   import mlp_pkg::*;
#(
   parameter int  N_IN  = 2,
   parameter int  N_HID = 2,
   parameter int  DW    = 10,
   localparam int NW    = N_HID*(N_IN+1) + N_HID + 1,
   localparam int AW    = $clog2(NW),
   localparam int ACC_W = acc_w(DW, N_IN)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_IN*DW-1:0]   x_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 y,
   output logic [N_HID-1:0]     h_vec,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [DW-1:0]        cfg_wdata,
   output logic                 cfg_err
);

   localparam int                   CW       = $clog2(N_IN + N_HID + 2);
   localparam logic [CW-1:0]        T_LAST   = CW'(N_IN);
   localparam logic [CW-1:0]        K_LAST   = CW'(N_HID);
   localparam logic [CW-1:0]        J_LAST   = CW'(N_HID - 1);
   localparam int                   OUT_BASE = N_HID*(N_IN+1);
   localparam logic [AW:0]          NW_LIM   = (AW+1)'(NW);
   localparam logic signed [DW-1:0] ONE      = DW'(1);

   state_t                  state_reg, state_next;
   logic [CW-1:0]           t_reg, t_next;
   logic [CW-1:0]           j_reg, j_next;
   logic signed [DW-1:0]    x_slice  [N_IN];
   logic signed [DW-1:0]    x_reg    [N_IN];
   logic signed [DW-1:0]    coef_reg [NW];
   logic [N_HID-1:0]        h_reg;
   logic                    y_reg;
   logic                    cfg_err_reg;

   logic                    in_hid, in_out, accept, cfg_ok, last_term, act;
   logic [AW-1:0]           rd_addr;
   logic signed [DW-1:0]    mul_a, mul_b;
   logic signed [ACC_W-1:0] mac_sum;

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_unpack
         assign x_slice[gi] = x_in[gi*DW +: DW];
      end
   endgenerate

   assign in_hid    = (state_reg == S_HID);
   assign in_out    = (state_reg == S_OUT);
   assign in_ready  = (state_reg == S_IDLE);
   assign out_valid = (state_reg == S_DONE);
   assign accept    = in_valid && in_ready;
   // Writes only while idle, so a running inference always sees one coefficient set.
   assign cfg_ok    = cfg_we && in_ready && ({1'b0, cfg_addr} < NW_LIM);
   assign last_term = (in_hid && t_reg == T_LAST) || (in_out && t_reg == K_LAST);
   assign act       = step(mac_sum[ACC_W-1], |mac_sum);

   assign y       = y_reg;
   assign h_vec   = h_reg;
   assign cfg_err = cfg_err_reg;

   // Coefficient address of the current term; the map is contiguous across both layers.
   always_comb begin
      rd_addr = '0;
      if (in_hid)
         rd_addr = AW'(coef_addr(int'(j_reg), int'(t_reg), N_IN));
      else if (in_out)
         rd_addr = AW'(OUT_BASE + int'(t_reg));
   end

   // MAC operands: weight times input, weight times hidden bit, or bias times one.
   always_comb begin
      mul_a = '0;
      for (int i = 0; i < NW; i++)
         if (rd_addr == AW'(i))
            mul_a = coef_reg[i];
      mul_b = '0;
      if (in_hid) begin
         if (t_reg == T_LAST)
            mul_b = ONE;
         else
            for (int i = 0; i < N_IN; i++)
               if (t_reg == CW'(i))
                  mul_b = x_reg[i];
      end else if (in_out) begin
         if (t_reg == K_LAST)
            mul_b = ONE;
         else
            for (int i = 0; i < N_HID; i++)
               if (t_reg == CW'(i))
                  mul_b = {{(DW-1){1'b0}}, h_reg[i]};
      end
   end

   mlp_mac #(
      .DW    (DW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept || last_term),
      .en    (in_hid || in_out),
      .a     (mul_a),
      .b     (mul_b),
      .sum   (mac_sum)
   );

   // Sequencer: walks term index t within neuron j, then the output neuron's terms.
   always_comb begin
      state_next = state_reg;
      t_next     = t_reg;
      j_next     = j_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               state_next = S_HID;
               t_next     = '0;
               j_next     = '0;
            end
         end
         S_HID: begin
            if (t_reg == T_LAST) begin
               t_next = '0;
               if (j_reg == J_LAST) begin
                  j_next     = '0;
                  state_next = S_OUT;
               end else begin
                  j_next = j_reg + 1'b1;
               end
            end else begin
               t_next = t_reg + 1'b1;
            end
         end
         S_OUT: begin
            if (t_reg == K_LAST) begin
               t_next     = '0;
               state_next = S_DONE;
            end else begin
               t_next = t_reg + 1'b1;
            end
         end
         default: begin
            if (out_ready)
               state_next = S_IDLE;
         end
      endcase
   end

   // Control state, input latch, result registers and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         t_reg       <= '0;
         j_reg       <= '0;
         h_reg       <= '0;
         y_reg       <= 1'b0;
         cfg_err_reg <= 1'b0;
         for (int i = 0; i < N_IN; i++)
            x_reg[i] <= '0;
      end else begin
         state_reg   <= state_next;
         t_reg       <= t_next;
         j_reg       <= j_next;
         cfg_err_reg <= cfg_we && !cfg_ok;
         if (accept)
            for (int i = 0; i < N_IN; i++)
               x_reg[i] <= x_slice[i];
         for (int i = 0; i < N_HID; i++)
            if (in_hid && t_reg == T_LAST && j_reg == CW'(i))
               h_reg[i] <= act;
         if (in_out && t_reg == K_LAST)
            y_reg <= act;
      end
   end

   // Coefficient register file; a write in the accept cycle is seen by that sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NW; i++)
            coef_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NW; i++)
            if (cfg_ok && cfg_addr == AW'(i))
               coef_reg[i] <= cfg_wdata;
      end
   end

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed bench for mlp_seq_engine (2-2-1, DW=10): vector table plus handshake corner cases.
module tb_mlp_seq_engine;

   localparam int DW = 10;
   localparam int NI = 2;
   localparam int NH = 2;
   localparam int NW = NH*(NI+1) + NH + 1;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [NI*DW-1:0] x_in;
   logic            out_valid;
   logic            out_ready;
   logic            y;
   logic [NH-1:0]   h_vec;
   logic            cfg_we;
   logic [3:0]      cfg_addr;
   logic [DW-1:0]   cfg_wdata;
   logic            cfg_err;

   int errors = 0;
   int checks = 0;
   int cs [5][NW];
   int cur_set = -1;

   typedef struct {
      int set;
      int x0;
      int x1;
      int h;
      int yv;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   mlp_seq_engine #(.N_IN(NI), .N_HID(NH), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .h_vec     (h_vec),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_err   (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [NI*DW-1:0] pack(input int a, input int b);
      return {DW'(b), DW'(a)};
   endfunction

   function automatic void model(input int s, input int x0, input int x1, output int h, output int yv);
      int xv [NI];
      int acc;
      xv[0] = x0;
      xv[1] = x1;
      h = 0;
      for (int j = 0; j < NH; j++) begin
         acc = cs[s][j*(NI+1)+NI];
         for (int i = 0; i < NI; i++)
            acc += cs[s][j*(NI+1)+i] * xv[i];
         if (acc > 0)
            h |= (1 << j);
      end
      acc = cs[s][NW-1];
      for (int j = 0; j < NH; j++)
         if (((h >> j) & 1) == 1)
            acc += cs[s][NH*(NI+1)+j];
      yv = (acc > 0) ? 1 : 0;
   endfunction

   task automatic cfg_write(input int addr, input int data, output int err);
      cfg_we    = 1'b1;
      cfg_addr  = 4'(addr);
      cfg_wdata = DW'(data);
      @(negedge clk);
      cfg_we = 1'b0;
      err    = int'(cfg_err);
   endtask

   task automatic load_set(input int s);
      int e;
      for (int i = 0; i < NW; i++)
         cfg_write(i, cs[s][i], e);
      cur_set = s;
   endtask

   // Waits for out_valid counting cycles from the cycle after accept; consumes with out_ready=1.
   task automatic wait_result(output int h, output int yv, output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      h  = int'(h_vec);
      yv = int'(y);
      @(negedge clk);
   endtask

   task automatic run_sample(input string name, input int x0, input int x1, output int h, output int yv, output int lat);
      int n;
      n = 0;
      in_valid = 1'b1;
      x_in     = pack(x0, x1);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_ready"}, int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(h, yv, lat);
   endtask

   initial begin
      int h, yv, lat, e, n;
      int sx0 [3];
      int sx1 [3];
      int acyc [3];
      int rcyc [3];
      int sent, got, cyc, eh, ey;
      bit pend;

      cs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      cs[1] = '{2, -1, -3, -1, 2, 1, -2, 3, 0};
      cs[2] = '{default: -512};
      cs[3] = '{1, 0, 0, 0, -1, 0, 2, -1, -1};

      vecs[0]  = '{0,    7,   -3, 0, 0};
      vecs[1]  = '{1,    3,    1, 1, 0};
      vecs[2]  = '{1,    0,    1, 2, 1};
      vecs[3]  = '{1,   -1,   -1, 0, 0};
      vecs[4]  = '{1,    5,    0, 1, 0};
      vecs[5]  = '{1,    2,    5, 2, 1};
      vecs[6]  = '{1,    4,    4, 3, 1};
      vecs[7]  = '{2, -512, -512, 3, 0};
      vecs[8]  = '{2,  511,  511, 0, 0};
      vecs[9]  = '{3,    1,   -1, 3, 0};
      vecs[10] = '{3,    1,    1, 1, 1};
      vecs[11] = '{3,    0,   -3, 2, 0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      x_in      = '0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({in_ready, out_valid, y, h_vec, cfg_err}), 32);
      rst_n = 1'b1;
      @(negedge clk);

      // Mid-stream reset must clear results and coefficients.
      load_set(1);
      run_sample("pre_rst", 4, 4, h, yv, lat);
      chk("pre_rst_h", h, 3);
      chk("pre_rst_y", yv, 1);
      in_valid = 1'b1;
      x_in     = pack(0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_async", int'({in_ready, out_valid, y, h_vec}), 16);
      @(negedge clk);
      rst_n   = 1'b1;
      cur_set = -1;
      @(negedge clk);
      chk("rst_no_result", int'(out_valid), 0);
      run_sample("rst_zero", 0, 1, h, yv, lat);
      chk("rst_zero_h", h, 0);
      chk("rst_zero_y", yv, 0);
      chk("rst_zero_lat", lat, 10);

      // Table-driven vectors.
      for (int v = 0; v < NV; v++) begin
         if (vecs[v].set != cur_set)
            load_set(vecs[v].set);
         run_sample($sformatf("vec%0d", v), vecs[v].x0, vecs[v].x1, h, yv, lat);
         chk($sformatf("vec%0d_h", v), h, vecs[v].h);
         chk($sformatf("vec%0d_y", v), yv, vecs[v].yv);
         chk($sformatf("vec%0d_lat", v), lat, 10);
         $display("vec %0d: x=(%0d,%0d) h=%0d y=%0d lat=%0d", v, vecs[v].x0, vecs[v].x1, h, yv, lat);
      end

      // Backpressure: result held, busy, new samples ignored.
      load_set(1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x_in      = pack(0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      x_in     = pack(3, 1);
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("bp_hold%0d", c), int'({out_valid, in_ready, y, h_vec}), 22);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", int'({out_valid, in_ready}), 1);
      chk("bp_result_kept", int'({y, h_vec}), 6);

      // Config guard: write during HID is dropped with a single-cycle error.
      in_valid = 1'b1;
      x_in     = pack(3, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      cfg_we    = 1'b1;
      cfg_addr  = 4'd5;
      cfg_wdata = DW'(100);
      @(negedge clk);
      cfg_we = 1'b0;
      chk("cfg_busy_err", int'(cfg_err), 1);
      @(negedge clk);
      chk("cfg_err_pulse", int'(cfg_err), 0);
      wait_result(h, yv, lat);
      chk("cfg_busy_h", h, 1);
      chk("cfg_busy_y", yv, 0);
      run_sample("cfg_nowrite", 3, 1, h, yv, lat);
      chk("cfg_nowrite_hy", h*2 + yv, 2);
      cfg_write(8, 5, e);
      chk("cfg_addr8_err", e, 0);
      run_sample("cfg_addr8", 3, 1, h, yv, lat);
      chk("cfg_addr8_hy", h*2 + yv, 3);
      cfg_write(9, -100, e);
      chk("cfg_addr9_err", e, 1);
      cfg_write(15, -100, e);
      chk("cfg_addr15_err", e, 1);
      run_sample("cfg_oob", 3, 1, h, yv, lat);
      chk("cfg_oob_hy", h*2 + yv, 3);

      // Write and accept in the same idle cycle: the sample uses the new value.
      cfg_we    = 1'b1;
      cfg_addr  = 4'd8;
      cfg_wdata = DW'(-10);
      in_valid  = 1'b1;
      x_in      = pack(3, 1);
      @(negedge clk);
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      chk("cfg_same_err", int'(cfg_err), 0);
      wait_result(h, yv, lat);
      chk("cfg_same_hy", h*2 + yv, 2);
      chk("cfg_same_lat", lat, 10);

      // Back-to-back random samples against the reference model.
      for (int i = 0; i < NW; i++)
         cs[4][i] = int'($urandom_range(1023)) - 512;
      for (int i = 0; i < 3; i++) begin
         sx0[i] = int'($urandom_range(1023)) - 512;
         sx1[i] = int'($urandom_range(1023)) - 512;
         acyc[i] = -1000;
         rcyc[i] = 1000;
      end
      load_set(4);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x_in      = pack(sx0[0], sx1[0]);
      sent = 0;
      got  = 0;
      cyc  = 0;
      pend = 1'b0;
      while (got < 3 && cyc < 300) begin
         if (pend) begin
            pend = 1'b0;
            if (sent < 3)
               x_in = pack(sx0[sent], sx1[sent]);
            else
               in_valid = 1'b0;
         end
         if (out_valid) begin
            model(4, sx0[got], sx1[got], eh, ey);
            chk($sformatf("b2b%0d_h", got), int'(h_vec), eh);
            chk($sformatf("b2b%0d_y", got), int'(y), ey);
            $display("b2b %0d: x=(%0d,%0d) h=%0d y=%0d cycle=%0d", got, sx0[got], sx1[got], int'(h_vec), int'(y), cyc);
            rcyc[got] = cyc;
            got++;
         end
         if (in_valid && in_ready && sent < 3) begin
            acyc[sent] = cyc;
            sent++;
            pend = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("b2b_count", got, 3);
      chk("b2b_first_lat", rcyc[0] - acyc[0], 10);
      chk("b2b_period1", rcyc[1] - rcyc[0], 11);
      chk("b2b_period2", rcyc[2] - rcyc[1], 11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
